// File: rtl/tcs_channel_sequencer.sv
// Colour sensor channel sequencer: steps the S2/S3 filter select, settles, gates edge counts, publishes them atomically.
// Define CLEAR_CHANNEL_EN to add a fourth (clear) channel and the clear_cnt output.
module tcs_channel_sequencer #(
  parameter int SETTLE_CYCLES = 10000,
  parameter int GATE_CYCLES   = 1000000,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             signal_in,
  output logic             S2,
  output logic             S3,
  output logic [CNT_W-1:0] red,
  output logic [CNT_W-1:0] green,
  output logic [CNT_W-1:0] blue,
`ifdef CLEAR_CHANNEL_EN
  output logic [CNT_W-1:0] clear_cnt,
`endif
  output logic             done_color,
  output logic             busy,
  output logic [1:0]       channel,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, STORE} state_t;

`ifdef CLEAR_CHANNEL_EN
  localparam logic [1:0] LAST_CH = 2'd3;
`else
  localparam logic [1:0] LAST_CH = 2'd2;
`endif
  localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]      GATE_LAST   = 32'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_timer;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_sh_r;
  logic [CNT_W-1:0] r_sh_g;
`ifdef CLEAR_CHANNEL_EN
  logic [CNT_W-1:0] r_sh_b;
`endif
  logic [1:0]       r_channel;
  logic [1:0]       w_ch_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync_d;
  logic             w_rise;
  logic             w_store;
  logic             w_last;

  // Filter select code for a channel index: R=00, G=11, B=01, clear=10.
  function automatic logic [1:0] filter_code(input logic [1:0] ch);
    case (ch)
      2'd0:    filter_code = 2'b00;
      2'd1:    filter_code = 2'b11;
      2'd2:    filter_code = 2'b01;
      default: filter_code = 2'b10;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= signal_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_rise  = r_sync2 & ~r_sync_d;
  assign w_store = (r_state == STORE);
  assign w_last  = (r_channel == LAST_CH);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_channel;
    case (r_state)
      IDLE: begin
        w_ch_nxt = 2'd0;
        if (enable) w_state_nxt = SETTLE;
      end
      SETTLE: if (r_timer == SETTLE_LAST) w_state_nxt = GATE;
      GATE:   if (r_timer == GATE_LAST) w_state_nxt = STORE;
      STORE: begin
        if (w_last) begin
          w_ch_nxt    = 2'd0;
          w_state_nxt = enable ? SETTLE : IDLE;
        end else begin
          w_ch_nxt    = r_channel + 2'd1;
          w_state_nxt = SETTLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer    <= '0;
      r_edge_cnt <= '0;
      r_sh_r     <= '0;
      r_sh_g     <= '0;
`ifdef CLEAR_CHANNEL_EN
      r_sh_b     <= '0;
      clear_cnt  <= '0;
`endif
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      done_color <= 1'b0;
      r_channel  <= 2'd0;
      S2         <= 1'b0;
      S3         <= 1'b0;
    end else begin
      done_color <= w_store & w_last;
      r_channel  <= w_ch_nxt;
      if (w_state_nxt != r_state)                   r_timer <= '0;
      else if (r_state == SETTLE || r_state == GATE) r_timer <= r_timer + 32'd1;
      // Settle discards strobes; gate counts them and sticks at full scale.
      if (r_state == SETTLE)
        r_edge_cnt <= '0;
      else if (r_state == GATE && w_rise && r_edge_cnt != CNT_MAX)
        r_edge_cnt <= r_edge_cnt + 1'b1;
      if (w_store) begin
        {S2, S3} <= filter_code(w_ch_nxt);
        case (r_channel)
          2'd0:    r_sh_r <= r_edge_cnt;
          2'd1:    r_sh_g <= r_edge_cnt;
`ifdef CLEAR_CHANNEL_EN
          2'd2:    r_sh_b <= r_edge_cnt;
`endif
          default: ;
        endcase
        // The last channel's count bypasses its shadow so all outputs update together.
        if (w_last) begin
          red   <= r_sh_r;
          green <= r_sh_g;
`ifdef CLEAR_CHANNEL_EN
          blue      <= r_sh_b;
          clear_cnt <= r_edge_cnt;
`else
          blue      <= r_edge_cnt;
`endif
        end
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign channel     = r_channel;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tcs_channel_sequencer.sv
// Bench for tcs_channel_sequencer: sensor model driven by S2/S3, scoreboard of expected published counts.
// Also builds with CLEAR_CHANNEL_EN, where the fourth channel and clear_cnt are checked.
module tb_tcs_channel_sequencer;
  localparam int S = 4;
  localparam int G = 100;
  localparam int W = 32;
  localparam int N = S + G + 1;
`ifdef CLEAR_CHANNEL_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 3;
`endif
  localparam int ROUND = NCH * N;

  logic clk = 1'b0;
  logic reset, enable, signal_in, en_s, sig_fast;
  logic S2, S3, done_color, busy;
  logic [1:0] channel, dbg_state;
  logic [W-1:0] red, green, blue;
  logic s_S2, s_S3, s_done, s_busy;
  logic [1:0] s_channel, s_dbg_state;
  logic [3:0] s_red, s_green, s_blue;
`ifdef CLEAR_CHANNEL_EN
  logic [W-1:0] clear_cnt;
  logic [3:0] s_clear;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int period_r = 10, period_g = 20, period_b = 4, period_c = 5;
  logic [4*W-1:0] exp_q[$];
  logic [1:0] seq_q[$];

  tcs_channel_sequencer #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .signal_in(signal_in),
    .S2(S2), .S3(S3), .red(red), .green(green), .blue(blue),
`ifdef CLEAR_CHANNEL_EN
    .clear_cnt(clear_cnt),
`endif
    .done_color(done_color), .busy(busy), .channel(channel), .o_dbg_state(dbg_state)
  );

  tcs_channel_sequencer #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .enable(en_s), .signal_in(sig_fast),
    .S2(s_S2), .S3(s_S3), .red(s_red), .green(s_green), .blue(s_blue),
`ifdef CLEAR_CHANNEL_EN
    .clear_cnt(s_clear),
`endif
    .done_color(s_done), .busy(s_busy), .channel(s_channel), .o_dbg_state(s_dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sensor model: square wave whose period follows the selected filter.
  initial begin
    int ph;
    int cur_p;
    ph = 0;
    signal_in = 1'b0;
    sig_fast = 1'b0;
    forever begin
      @(negedge clk);
      case ({S2, S3})
        2'b00:   cur_p = period_r;
        2'b11:   cur_p = period_g;
        2'b01:   cur_p = period_b;
        default: cur_p = period_c;
      endcase
      ph = ph + 1;
      if (ph >= cur_p) ph = 0;
      signal_in = (ph < cur_p / 2);
      sig_fast = ~sig_fast;
    end
  end

  // Driver tasks
  task automatic pulse_enable();
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    logic [1:0] last;
    seen = 1'b0;
    cycles = 0;
    seq_q.delete();
    last = {S2, S3};
    seq_q.push_back(last);
    while (!seen && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (done_color) seen = 1'b1;
      else if ({S2, S3} != last) begin
        last = {S2, S3};
        seq_q.push_back(last);
      end
    end
  endtask

  function automatic logic [4*W-1:0] pack_exp(input int r, input int g, input int b, input int c);
    pack_exp = {W'(c), W'(b), W'(g), W'(r)};
  endfunction

  function automatic bit off_by_more(input logic [W-1:0] a, input logic [W-1:0] e);
    off_by_more = (a > e + 1) || (a + 1 < e);
  endfunction

  // Scoreboard pop: one call per observed done_color.
  task automatic sb_check(input string tag);
    logic [4*W-1:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s sb_empty: done_color with no expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      if (off_by_more(red, e[W-1:0]) || off_by_more(green, e[2*W-1:W]) || off_by_more(blue, e[3*W-1:2*W])
`ifdef CLEAR_CHANNEL_EN
          || off_by_more(clear_cnt, e[4*W-1:3*W])
`endif
         ) begin
        n_fail++;
        $display("FAIL %s counts: got r=%0d g=%0d b=%0d expected r=%0d g=%0d b=%0d c=%0d (+-1)",
                 tag, red, green, blue, e[W-1:0], e[2*W-1:W], e[3*W-1:2*W], e[4*W-1:3*W]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; en_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({S2, S3, done_color, busy, channel, dbg_state} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got S2S3=%b%b done=%b busy=%b ch=%0d st=%0d required all 0",
               S2, S3, done_color, busy, channel, dbg_state);
    end
    n_tests++;
    if (red !== '0 || green !== '0 || blue !== '0
`ifdef CLEAR_CHANNEL_EN
        || clear_cnt !== '0
`endif
       ) begin
      n_fail++;
      $display("FAIL reset_counts: got r=%0d g=%0d b=%0d required 0", red, green, blue);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_round();
    int cycles;
    bit seen;
    logic [1:0] exp_seq[$];
    period_r = 10; period_g = 20; period_b = 4; period_c = 5;
    exp_q.push_back(pack_exp(10, 5, 25, 20));
    exp_seq = '{2'b00, 2'b11, 2'b01};
`ifdef CLEAR_CHANNEL_EN
    exp_seq.push_back(2'b10);
`endif
    pulse_enable();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_start: got busy=%b required 1", busy);
    end
    wait_done(ROUND + 20, cycles, seen);
    n_tests++;
    if (!seen || cycles !== ROUND) begin
      n_fail++;
      $display("FAIL single_latency: got seen=%0d cycles=%0d required %0d", seen, cycles, ROUND);
    end
    if (seen) sb_check("single");
    n_tests++;
    if (seq_q.size() !== exp_seq.size()) begin
      n_fail++;
      $display("FAIL single_seq_len: got %0d filter codes required %0d", seq_q.size(), exp_seq.size());
    end else begin
      foreach (exp_seq[i]) begin
        n_tests++;
        if (seq_q[i] !== exp_seq[i]) begin
          n_fail++;
          $display("FAIL single_seq[%0d]: got S2S3=%b required %b", i, seq_q[i], exp_seq[i]);
        end
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (done_color !== 1'b0 || busy !== 1'b0 || {S2, S3} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_after: got done=%b busy=%b S2S3=%b%b required 0 0 00", done_color, busy, S2, S3);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    bit seen;
    period_r = 10; period_g = 10; period_b = 10; period_c = 10;
    for (int k = 0; k < 3; k++) exp_q.push_back(pack_exp(10, 10, 10, 10));
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    wait_done(ROUND + 20, cycles, seen);
    n_tests++;
    if (!seen || cycles !== ROUND) begin
      n_fail++;
      $display("FAIL b2b_first: got seen=%0d cycles=%0d required %0d", seen, cycles, ROUND);
    end
    if (seen) sb_check("b2b_r0");
    for (int k = 1; k < 3; k++) begin
      repeat (150) @(posedge clk);
      #1;
      n_tests++;
      if (done_color !== 1'b0 || red !== W'(10) || green !== W'(10) || blue !== W'(10)) begin
        n_fail++;
        $display("FAIL b2b_hold%0d: got done=%b r=%0d g=%0d b=%0d required 0 10 10 10", k, done_color, red, green, blue);
      end
      if (k == 2) enable = 1'b0;
      wait_done(ROUND, cycles, seen);
      n_tests++;
      if (!seen || cycles !== ROUND - 150) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: got seen=%0d cycles=%0d required %0d", k, seen, cycles + 150, ROUND);
      end
      if (seen) sb_check("b2b_round");
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || done_color !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got busy=%b done=%b required 0 0", busy, done_color);
    end
  endtask

  task automatic test_saturation();
    int cycles;
    bit seen;
    seen = 1'b0;
    cycles = 0;
    @(posedge clk); #1;
    en_s = 1'b1;
    @(posedge clk); #1;
    en_s = 1'b0;
    while (!seen && cycles < ROUND + 20) begin
      @(posedge clk); #1;
      cycles++;
      if (s_done) seen = 1'b1;
    end
    n_tests++;
    if (!seen || cycles !== ROUND) begin
      n_fail++;
      $display("FAIL sat_latency: got seen=%0d cycles=%0d required %0d", seen, cycles, ROUND);
    end
    n_tests++;
    if (s_red !== 4'd15 || s_green !== 4'd15 || s_blue !== 4'd15
`ifdef CLEAR_CHANNEL_EN
        || s_clear !== 4'd15
`endif
       ) begin
      n_fail++;
      $display("FAIL sat_counts: got r=%0d g=%0d b=%0d required 15", s_red, s_green, s_blue);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    bit seen;
    int pulses;
    period_r = 10; period_g = 20; period_b = 4; period_c = 5;
    pulse_enable();
    repeat (N + S + 10) @(posedge clk);
    #1;
    n_tests++;
    if (channel !== 2'd1 || {S2, S3} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_green: got ch=%0d S2S3=%b%b required 1 11", channel, S2, S3);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++;
    if ({S2, S3, busy, done_color, channel} !== 6'b0 || red !== '0 || green !== '0 || blue !== '0) begin
      n_fail++;
      $display("FAIL rstmid_state: got S2S3=%b%b busy=%b done=%b ch=%0d r=%0d g=%0d b=%0d required all 0",
               S2, S3, busy, done_color, channel, red, green, blue);
    end
    pulses = 0;
    for (int i = 0; i < 2 * ROUND; i++) begin
      @(posedge clk); #1;
      if (done_color) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL rstmid_no_done: got %0d pulses required 0", pulses);
    end
    exp_q.push_back(pack_exp(10, 5, 25, 20));
    pulse_enable();
    wait_done(ROUND + 20, cycles, seen);
    n_tests++;
    if (!seen || cycles !== ROUND) begin
      n_fail++;
      $display("FAIL rstmid_fresh: got seen=%0d cycles=%0d required %0d", seen, cycles, ROUND);
    end
    if (seen) sb_check("rstmid_fresh");
  endtask

  task automatic test_drop_enable();
    int cycles;
    bit seen;
    int pulses;
    exp_q.push_back(pack_exp(10, 5, 25, 20));
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0;
    wait_done(ROUND + 20, cycles, seen);
    n_tests++;
    if (!seen || cycles !== ROUND - 2) begin
      n_fail++;
      $display("FAIL drop_latency: got seen=%0d cycles=%0d required %0d", seen, cycles + 2, ROUND);
    end
    if (seen) sb_check("drop");
    pulses = 0;
    for (int i = 0; i < 2 * ROUND; i++) begin
      @(posedge clk); #1;
      if (done_color) pulses++;
    end
    n_tests++;
    if (pulses !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle: got pulses=%0d busy=%b required 0 0", pulses, busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    en_s = 1'b0;
    test_reset();
    test_single_round();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_drop_enable();
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d unconsumed entries required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
